// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates the instruction-fetch and data ports onto a single
//               backend memory port. Data requests normally win, and a
//               starvation counter bounds how long a pending fetch can wait.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,

    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,

    output logic              stall
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BUSY_I = 3'd1,
        S_BUSY_D = 3'd2,
        S_RESP_I = 3'd3,
        S_RESP_D = 3'd4
    } state_t;

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    state_t     r_state;
    logic [3:0] r_starve_cnt;
    logic       w_fetch_wins;

    // A fetch wins when it is alone, or when data has already had its quota.
    assign w_fetch_wins = if_req & (~d_req | (r_starve_cnt == c_starve_max));

    assign stall = (if_req & ~if_done) | (d_req & ~d_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= 4'd0;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            if_done      <= 1'b0;
            d_done       <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fetch_wins) begin
                        r_state      <= S_BUSY_I;
                        r_starve_cnt <= 4'd0;
                        m_req        <= 1'b1;
                        m_we         <= 1'b0;
                        m_addr       <= if_addr;
                    end else if (d_req) begin
                        r_state <= S_BUSY_D;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        if (!if_req) begin
                            r_starve_cnt <= 4'd0;
                        end else if (r_starve_cnt != c_starve_max) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end else begin
                        r_starve_cnt <= 4'd0;
                    end
                end
                S_BUSY_I: begin
                    if (m_ack) begin
                        r_state  <= S_RESP_I;
                        m_req    <= 1'b0;
                        if_rdata <= m_rdata;
                        if_done  <= 1'b1;
                    end
                end
                S_BUSY_D: begin
                    if (m_ack) begin
                        r_state <= S_RESP_D;
                        m_req   <= 1'b0;
                        d_done  <= 1'b1;
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                    end
                end
                S_RESP_I, S_RESP_D: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    m_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed, table-driven bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;
    logic        stall;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic        ack;
        logic [31:0] mrd;
        logic        e_mreq;
        logic        chk_m;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic        e_idone;
        logic        e_ddone;
        logic        e_stall;
        logic [31:0] e_irdata;
        logic [31:0] e_drdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic ireq, input logic [31:0] iaddr,
        input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
        input logic ack, input logic [31:0] mrd,
        input logic e_mreq, input logic chk_m, input logic e_mwe,
        input logic [31:0] e_maddr, input logic [31:0] e_mwd,
        input logic e_idone, input logic e_ddone, input logic e_stall,
        input logic [31:0] e_irdata, input logic [31:0] e_drdata);
        vec_t v;
        v.ireq = ireq;  v.iaddr = iaddr;  v.dreq = dreq;  v.dwe = dwe;
        v.daddr = daddr;  v.dwd = dwd;  v.ack = ack;  v.mrd = mrd;
        v.e_mreq = e_mreq;  v.chk_m = chk_m;  v.e_mwe = e_mwe;
        v.e_maddr = e_maddr;  v.e_mwd = e_mwd;  v.e_idone = e_idone;
        v.e_ddone = e_ddone;  v.e_stall = e_stall;
        v.e_irdata = e_irdata;  v.e_drdata = e_drdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int n_d;
        bit got_f;
        bit seen;
        bit prev_mreq;
        int lat;

        // Fetch only, ack in cycle 3.
        tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 1, 0, 32'h40, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 1, 0, 32'h40, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 1, 32'h2008_0005, 1, 1, 0, 32'h40, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0, 0, 32'h2008_0005, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2008_0005, 0));
        // Simultaneous fetch + load, zero-wait backend: data first.
        tbl.push_back(mk(1, 32'h80, 1, 0, 32'h100, 32'h0BAD_F00D, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2008_0005, 0));
        tbl.push_back(mk(1, 32'h80, 1, 0, 32'h100, 32'h0BAD_F00D, 1, 32'hA5A5_0001, 1, 1, 0, 32'h100, 32'h0BAD_F00D, 0, 0, 1, 32'h2008_0005, 0));
        tbl.push_back(mk(1, 32'h80, 1, 0, 32'h100, 32'h0BAD_F00D, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 1, 1, 32'h2008_0005, 32'hA5A5_0001));
        tbl.push_back(mk(1, 32'h80, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2008_0005, 32'hA5A5_0001));
        tbl.push_back(mk(1, 32'h80, 0, 0, 0, 0, 1, 32'h5A5A_0002, 1, 1, 0, 32'h80, 32'h0BAD_F00D, 0, 0, 1, 32'h2008_0005, 32'hA5A5_0001));
        tbl.push_back(mk(1, 32'h80, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0, 0, 32'h5A5A_0002, 32'hA5A5_0001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5A5A_0002, 32'hA5A5_0001));
        // Store: d_rdata must keep the earlier load value.
        tbl.push_back(mk(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A_0002, 32'hA5A5_0001));
        tbl.push_back(mk(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF, 0, 0, 1, 1, 1, 32'h200, 32'hDEAD_BEEF, 0, 0, 1, 32'h5A5A_0002, 32'hA5A5_0001));
        tbl.push_back(mk(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF, 1, 32'h1234_5678, 1, 1, 1, 32'h200, 32'hDEAD_BEEF, 0, 0, 1, 32'h5A5A_0002, 32'hA5A5_0001));
        tbl.push_back(mk(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h5A5A_0002, 32'hA5A5_0001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5A5A_0002, 32'hA5A5_0001));
        // Stray ack while idle.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h7777_7777, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5A5A_0002, 32'hA5A5_0001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5A5A_0002, 32'hA5A5_0001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5A5A_0002, 32'hA5A5_0001));

        // Reset: stall still follows the requests while reset is high.
        if_req = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("stall_in_reset", 32'(stall), 32'd1);
        if_req = 1'b0;
        #1 chk("stall_in_reset_idle", 32'(stall), 32'd0);
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_d_done", 32'(d_done), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_starve", 32'(dut.r_starve_cnt), 32'd0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            if_req = tbl[i].ireq;  if_addr = tbl[i].iaddr;
            d_req = tbl[i].dreq;   d_we = tbl[i].dwe;
            d_addr = tbl[i].daddr; d_wdata = tbl[i].dwd;
            m_ack = tbl[i].ack;    m_rdata = tbl[i].mrd;
            #1;
            chk($sformatf("v%0d_m_req", i), 32'(m_req), 32'(tbl[i].e_mreq));
            if (tbl[i].chk_m) begin
                chk($sformatf("v%0d_m_we", i), 32'(m_we), 32'(tbl[i].e_mwe));
                chk($sformatf("v%0d_m_addr", i), m_addr, tbl[i].e_maddr);
                chk($sformatf("v%0d_m_wdata", i), m_wdata, tbl[i].e_mwd);
            end
            chk($sformatf("v%0d_if_done", i), 32'(if_done), 32'(tbl[i].e_idone));
            chk($sformatf("v%0d_d_done", i), 32'(d_done), 32'(tbl[i].e_ddone));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("v%0d_if_rdata", i), if_rdata, tbl[i].e_irdata);
            chk($sformatf("v%0d_d_rdata", i), d_rdata, tbl[i].e_drdata);
        end

        // Starvation guard: data is re-requested continuously with a fetch pending.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1;  d_we = 1'b0; d_addr = 32'h400; d_wdata = 32'h0;
        m_rdata = 32'h1111_0000; m_ack = 1'b0;
        n_d = 0; got_f = 1'b0; prev_mreq = 1'b0;
        for (int c = 0; c < 100 && !got_f; c++) begin
            @(negedge clk);
            m_ack = m_req;
            if (m_req && !prev_mreq) begin
                if (m_addr == 32'h400) n_d++;
                else if (m_addr == 32'h300) got_f = 1'b1;
            end
            prev_mreq = m_req;
        end
        chk("starve_fetch_granted", 32'(got_f), 32'd1);
        chk("starve_data_grants", 32'(n_d), 32'd4);
        chk("starve_cnt_after_fetch_grant", 32'(dut.r_starve_cnt), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            m_ack = m_req;
            if (if_done) seen = 1'b1;
        end
        chk("starve_if_done_seen", 32'(seen), 32'd1);
        chk("starve_if_rdata", if_rdata, 32'h1111_0000);
        if_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            m_ack = m_req;
            if (d_done) seen = 1'b1;
        end
        chk("starve_tail_d_done", 32'(seen), 32'd1);
        d_req = 1'b0; m_ack = 1'b0;
        @(negedge clk);
        #1 chk("starve_cnt_cleared_idle", 32'(dut.r_starve_cnt), 32'd0);

        // Reset while a load is waiting in BUSY_D, then a stray late ack.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; m_rdata = 32'h9999_9999;
        @(negedge clk);
        #1 chk("rmid_m_req_busy", 32'(m_req), 32'd1);
        @(negedge clk);
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rmid_m_req_after_reset", 32'(m_req), 32'd0);
        chk("rmid_no_d_done_0", 32'(d_done), 32'd0);
        chk("rmid_d_rdata_cleared", d_rdata, 32'd0);
        @(negedge clk);
        m_ack = 1'b1;
        #1 chk("rmid_no_d_done_1", 32'(d_done), 32'd0);
        @(negedge clk);
        m_ack = 1'b0;
        #1 chk("rmid_stray_m_req", 32'(m_req), 32'd0);
        chk("rmid_no_d_done_2", 32'(d_done), 32'd0);
        chk("rmid_d_rdata_kept", d_rdata, 32'd0);

        // The next fetch completes with zero-wait latency (done in cycle 2).
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h600; m_rdata = 32'hCAFE_0006;
        lat = -1;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            @(negedge clk);
            m_ack = m_req;
            if (if_done) lat = c;
        end
        chk("post_reset_fetch_latency", 32'(lat), 32'd2);
        chk("post_reset_fetch_rdata", if_rdata, 32'hCAFE_0006);
        if_req = 1'b0; m_ack = 1'b0;
        @(negedge clk);
        #1 chk("post_reset_idle_stall", 32'(stall), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
